// File: rtl/fm_tx_ctrl.sv
// ---------------------------------------------------------------------------
// fm_tx_ctrl
//   Sample-rate controller for an FM transmitter. Audio samples arriving on a
//   valid/ready stream are converted to a frequency control word for the NCO:
//   fcw = carrier + (signed sample << dev_shift), wrapping modulo 2^FCW_W.
//   A programmable divider paces sample consumption. A one-entry holding
//   register decouples the source from the tick. Missed ticks are counted.
//
// Ports
//   clk, rst_n      system clock, synchronous active-low reset
//   cfg_en          transmit enable (level)
//   cfg_div         sample period minus one, in clk cycles
//   cfg_carrier     carrier frequency control word
//   cfg_dev_shift   deviation scale (left shift of the signed sample)
//   s_valid/s_data  audio sample stream (offset binary), s_ready back-pressure
//   fcw, fcw_valid  control word to the modulator and its update strobe
//   tx_active       high while PRIME, RUN or DRAIN
//   underrun_cnt    saturating count of ticks with no sample available
//   state           IDLE=0, PRIME=1, RUN=2, DRAIN=3
// ---------------------------------------------------------------------------
module fm_tx_ctrl #(
  parameter int SMP_W = 10,
  parameter int FCW_W = 32,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [FCW_W-1:0] cfg_carrier,
  input  logic [3:0]       cfg_dev_shift,
  input  logic             s_valid,
  input  logic [SMP_W-1:0] s_data,
  output logic             s_ready,
  output logic [FCW_W-1:0] fcw,
  output logic             fcw_valid,
  output logic             tx_active,
  output logic [7:0]       underrun_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lat_div;
  logic [FCW_W-1:0] lat_car;
  logic [3:0]       lat_shift;
  logic             hold_vld;
  logic [SMP_W-1:0] hold_data;
  logic             accept;
  logic             tick;

  // Carrier plus scaled deviation. Flipping the MSB turns offset binary into
  // two's complement; the sum wraps by design so the NCO phase step stays
  // continuous across the word boundary.
  function automatic logic [FCW_W-1:0] mod_word(input logic [FCW_W-1:0] car,
                                                input logic [3:0]       sh,
                                                input logic [SMP_W-1:0] smp);
    logic signed [SMP_W-1:0] dev;
    logic signed [FCW_W-1:0] dev_ext;
    dev     = {~smp[SMP_W-1], smp[SMP_W-2:0]};
    dev_ext = {{(FCW_W-SMP_W){dev[SMP_W-1]}}, dev};
    return car + FCW_W'(dev_ext <<< sh);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign s_ready   = ((state == ST_PRIME) || (state == ST_RUN)) && !hold_vld;
  assign accept    = s_valid && s_ready;
  assign tick      = (cnt == '0);
  assign tx_active = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      fcw          <= '0;
      fcw_valid    <= 1'b0;
      underrun_cnt <= '0;
      cnt          <= '0;
      hold_vld     <= 1'b0;
      lat_div      <= '0;
      lat_car      <= '0;
      lat_shift    <= '0;
    end else begin
      fcw_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_en) begin
            lat_div      <= cfg_div;
            lat_car      <= cfg_carrier;
            lat_shift    <= cfg_dev_shift;
            underrun_cnt <= '0;
            state        <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          // Abort wins over a same-cycle handshake; that sample is dropped.
          if (!cfg_en) begin
            fcw   <= lat_car;
            state <= ST_IDLE;
          end else if (accept) begin
            fcw       <= mod_word(lat_car, lat_shift, s_data);
            fcw_valid <= 1'b1;
            cnt       <= lat_div;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= tick ? lat_div : cnt - DIV_W'(1);
          if (tick) begin
            if (hold_vld) begin
              fcw       <= mod_word(lat_car, lat_shift, hold_data);
              fcw_valid <= 1'b1;
              hold_vld  <= 1'b0;
            end else if (accept) begin
              // Bypass: sample arriving exactly on the tick is used directly.
              fcw       <= mod_word(lat_car, lat_shift, s_data);
              fcw_valid <= 1'b1;
            end else begin
              underrun_cnt <= sat_inc(underrun_cnt);
            end
          end else if (accept) begin
            hold_vld <= 1'b1;
          end
          if (!cfg_en) state <= ST_DRAIN;
        end
        default: begin
          cnt <= tick ? lat_div : cnt - DIV_W'(1);
          if (tick) begin
            fcw       <= lat_car;
            fcw_valid <= 1'b1;
            hold_vld  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Holding register payload; only meaningful while hold_vld is set.
  always_ff @(posedge clk) begin
    if ((state == ST_RUN) && accept && !tick) hold_data <= s_data;
  end

endmodule
